// File: rtl/bsg_fifo_1r1w_param.sv
// Parametrised single-clock FIFO: ready/valid enqueue side, valid/yumi dequeue side.
// Pointers wrap explicitly at els_p-1 so non-power-of-two depths need no spare entries.
module bsg_fifo_1r1w_param #(
    parameter  int width_p        = 32,
    parameter  int els_p          = 2,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_width_lp-1:0]   last_ptr_lp   = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wptr_q, wptr_d;
    logic [ptr_width_lp-1:0]   rptr_q, rptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
        if (els_p == 1 || p == last_ptr_lp) begin
            return '0;
        end
        return p + ptr_width_lp'(1);
    endfunction

    // Flags depend on registered state only, so ready_o has no path from yumi_i.
    assign ready_o = (count_q != full_count_lp);
    assign v_o     = (count_q != '0);
    assign count_o = count_q;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = ptr_next(wptr_q);
        end
        if (deq) begin
            rptr_d = ptr_next(rptr_q);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Decoded read mux keeps the index width legal for every depth, including els_p=1.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < els_p; i++) begin
            if (rptr_q == ptr_width_lp'(i)) begin
                data_o = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; v_o guards stale contents.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (enq && wptr_q == ptr_width_lp'(i)) begin
                mem_q[i] <= data_i;
            end
        end
    end

`ifndef SYNTHESIS
    yumi_only_when_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif

endmodule
